// File: rtl/mem_test_sequencer_pkg.sv
// Shared constants for the memory test sequencer: FSM state codes, pattern
// mode codes and the 4-bit LFSR (x^4 + x^3 + 1) tap mask with its step function.
package mem_test_sequencer_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [1:0] PAT_ADDR = 2'd0;
    localparam logic [1:0] PAT_CHK  = 2'd1;
    localparam logic [1:0] PAT_INV  = 2'd2;
    localparam logic [1:0] PAT_LFSR = 2'd3;

    localparam int         LFSR_W    = 4;
    localparam logic [3:0] LFSR_TAPS = 4'b1100;

    // Fibonacci form: feedback is the XOR of the tapped bits, shifted in at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mem_test_sequencer_pattern_gen.sv
// mem_pattern_gen: maps (mode, low address bits, LFSR value) to a test pattern
// and steps the LFSR. Shared by the write and read phases of the sequencer.
module mem_pattern_gen
    import mem_test_sequencer_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] addr,
    input  logic [LFSR_W-1:0] lfsr_pat,
    input  logic [LFSR_W-1:0] lfsr_cur,
    output logic [LFSR_W-1:0] lfsr_next,
    output logic [DATA_W-1:0] pattern
);

    assign lfsr_next = lfsr_step(lfsr_cur);

    always_comb begin
        pattern = '0;
        case (mode)
            PAT_ADDR: pattern = addr;
            PAT_CHK:  pattern = addr[0] ? DATA_W'(4'h5) : DATA_W'(4'hA);
            PAT_INV:  pattern = ~addr;
            PAT_LFSR: pattern = DATA_W'(lfsr_pat);
            default:  pattern = '0;
        endcase
    end

endmodule

// File: rtl/mem_test_sequencer.sv
// Memory test sequencer: writes a pattern to every address, reads it back and
// counts mismatches. Optional MEM_SEQ_ERR_CAPTURE_EN adds first-mismatch capture.
module mem_test_sequencer
    import mem_test_sequencer_pkg::*;
#(
    parameter int              ADDR_W   = 5,
    parameter int              DATA_W   = 4,
    parameter int              READ_LAT = 1,
    parameter logic [LFSR_W-1:0] SEED   = 4'h9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
`ifdef MEM_SEQ_ERR_CAPTURE_EN
    output logic              first_err_valid,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
`endif
    output logic [2:0]        state
);

    localparam int             FLUSH_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [ADDR_W:0] ERR_MAX = (ADDR_W+1)'(2**ADDR_W);

    logic [1:0]         mode_q;
    logic [LFSR_W-1:0]  lfsr_q;
    logic [DATA_W-1:0]  exp_q;
    logic [FLUSH_W-1:0] flush_cnt;
    logic               pipe_vld [READ_LAT];
    logic [DATA_W-1:0]  pipe_exp [READ_LAT];
`ifdef MEM_SEQ_ERR_CAPTURE_EN
    logic [ADDR_W-1:0]  pipe_addr [READ_LAT];
`endif

    logic               start_ok;
    logic               last_addr;
    logic               advance;
    logic [1:0]         gen_mode;
    logic [DATA_W-1:0]  gen_addr;
    logic [LFSR_W-1:0]  gen_lfsr;
    logic [LFSR_W-1:0]  lfsr_nx;
    logic [DATA_W-1:0]  gen_pat;
    logic               mismatch;
    logic [ADDR_W:0]    err_next;

    assign start_ok  = start && (state == S_IDLE || state == S_DONE);
    assign last_addr = (mem_address == '1);
    assign advance   = (state == S_WRITE || state == S_READ) && !last_addr;

    // The generator always produces the pattern for the address presented next cycle.
    assign gen_mode = start_ok ? mode : mode_q;
    assign gen_addr = advance ? mem_address[DATA_W-1:0] + DATA_W'(1) : '0;
    assign gen_lfsr = advance ? lfsr_nx : SEED;

    mem_pattern_gen #(.DATA_W(DATA_W)) u_pattern_gen (
        .mode      (gen_mode),
        .addr      (gen_addr),
        .lfsr_pat  (gen_lfsr),
        .lfsr_cur  (lfsr_q),
        .lfsr_next (lfsr_nx),
        .pattern   (gen_pat)
    );

    assign mismatch = pipe_vld[READ_LAT-1] && (mem_data_out != pipe_exp[READ_LAT-1]);
    assign pass     = done && (err_count == '0);

    always_comb begin
        err_next = err_count;
        if (start_ok)
            err_next = '0;
        else if (mismatch && err_count < ERR_MAX)
            err_next = err_count + (ADDR_W+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            mem_address <= '0;
            mem_data_in <= '0;
            mem_write   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_count   <= '0;
            mode_q      <= '0;
            lfsr_q      <= SEED;
            exp_q       <= '0;
            flush_cnt   <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_exp[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= (state == S_READ);
            pipe_exp[0] <= exp_q;
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_exp[i] <= pipe_exp[i-1];
            end
            err_count <= err_next;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        state       <= S_WRITE;
                        mode_q      <= mode;
                        mem_address <= '0;
                        mem_data_in <= gen_pat;
                        mem_write   <= 1'b1;
                        lfsr_q      <= SEED;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (last_addr) begin
                        state       <= S_GAP;
                        mem_address <= '0;
                        mem_data_in <= '0;
                        mem_write   <= 1'b0;
                    end else begin
                        mem_address <= mem_address + ADDR_W'(1);
                        mem_data_in <= gen_pat;
                        lfsr_q      <= lfsr_nx;
                    end
                end
                S_GAP: begin
                    state       <= S_READ;
                    mem_address <= '0;
                    lfsr_q      <= SEED;
                    exp_q       <= gen_pat;
                end
                S_READ: begin
                    if (last_addr) begin
                        state       <= S_FLUSH;
                        mem_address <= '0;
                        flush_cnt   <= '0;
                    end else begin
                        mem_address <= mem_address + ADDR_W'(1);
                        exp_q       <= gen_pat;
                        lfsr_q      <= lfsr_nx;
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt == FLUSH_W'(READ_LAT-1)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt + FLUSH_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MEM_SEQ_ERR_CAPTURE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
            first_err_data  <= '0;
            for (int i = 0; i < READ_LAT; i++)
                pipe_addr[i] <= '0;
        end else begin
            pipe_addr[0] <= mem_address;
            for (int i = 1; i < READ_LAT; i++)
                pipe_addr[i] <= pipe_addr[i-1];
            if (start_ok) begin
                first_err_valid <= 1'b0;
                first_err_addr  <= '0;
                first_err_data  <= '0;
            end else if (mismatch && !first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_addr  <= pipe_addr[READ_LAT-1];
                first_err_data  <= mem_data_out;
            end
        end
    end
`endif

endmodule
